// File: rtl/pn_sched_pkg.sv
// Shared definitions for the PN frame scheduler.
//   CNT_W      : width of symbol/frame counters and the n_frames input
//   state_t    : scheduler FSM state encoding
//   lfsr_next  : one-step advance of the 8-bit PN LFSR (period 255)
package pn_sched_pkg;

    localparam int CNT_W = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SYNC = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_PRE  = ST_PRE,
        S_SYNC = ST_SYNC,
        S_PAY  = ST_PAY,
        S_GAP  = ST_GAP
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        lfsr_next = {r[6], r[5] ^ r[7], r[4] ^ r[7], r[3] ^ r[7],
                     r[2], r[1], r[0], r[7]};
    endfunction

endpackage

// File: rtl/pn_lfsr8.sv
// 8-bit PN LFSR with synchronous load-to-SEED and advance enables.
//   clk, rst_n : clock, synchronous active-low reset (loads SEED)
//   load       : reload SEED (has priority over adv)
//   adv        : step one position
//   msb        : current LFSR bit 7 (the payload symbol)
//   nxt_msb    : bit 7 after one advance (the following payload symbol)
module pn_lfsr8 import pn_sched_pkg::*; #(
    parameter logic [7:0] SEED = 8'hff
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic adv,
    output logic msb,
    output logic nxt_msb
);

    logic [7:0] q;
    logic [7:0] q_nxt;

    assign q_nxt   = lfsr_next(q);
    assign msb     = q[7];
    assign nxt_msb = q_nxt[7];

    always_ff @(posedge clk) begin
        if (!rst_n)    q <= SEED;
        else if (load) q <= SEED;
        else if (adv)  q <= q_nxt;
    end

endmodule

// File: rtl/pn_frame_sched.sv
// Frame scheduler: preamble (1,0,1,0..), sync word (MSB first), PN payload,
// idle gap, repeated per run. Symbols are paced at SYM_DIV clocks and handed
// out over a registered valid/ready handshake.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, stop         : run control pulses (stop takes effect after payload)
//   n_frames            : frames per run, sampled on start (0 = continuous)
//   sym_valid/sym_ready : symbol handshake
//   sym_bit             : symbol value
//   sym_first/sym_last  : first symbol of frame / last payload symbol
//   busy                : run in progress
//   frame_cnt           : frames completed since reset
module pn_frame_sched import pn_sched_pkg::*; #(
    parameter logic [7:0] SEED      = 8'hff,
    parameter int         SYM_DIV   = 4,
    parameter int         PRE_LEN   = 8,
    parameter logic [7:0] SYNC_WORD = 8'hb5,
    parameter int         PAY_LEN   = 64,
    parameter int         GAP_LEN   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] n_frames,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             sym_bit,
    output logic             sym_first,
    output logic             sym_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    // Pace reload values: after an accept the counter runs down to 1 and the
    // next symbol becomes valid the cycle after, i.e. reload = interval - 1.
    localparam logic [CNT_W-1:0] PACE_SYM = CNT_W'(SYM_DIV - 1);
    localparam logic [CNT_W-1:0] PACE_GAP = CNT_W'(SYM_DIV * (GAP_LEN + 1) - 1);
    localparam logic [CNT_W-1:0] PRE_END  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_END  = CNT_W'(PAY_LEN - 1);
    localparam state_t           FIRST_ST  = (PRE_LEN > 0) ? S_PRE : S_SYNC;
    localparam logic             FIRST_BIT = (PRE_LEN > 0) ? 1'b1 : SYNC_WORD[7];

    state_t           state;
    logic [CNT_W-1:0] sym_idx;
    logic [CNT_W-1:0] sym_idx_inc;
    logic [CNT_W-1:0] pace;
    logic [CNT_W-1:0] nf_q;
    logic [CNT_W-1:0] run_frames;
    logic             stop_q;
    logic             lfsr_msb, lfsr_nxt_msb;
    logic             accept, pay_end, run_done, gap_end;
    logic             lfsr_load, lfsr_adv;

    assign accept      = sym_valid & sym_ready;
    assign sym_idx_inc = sym_idx + 1'b1;
    assign pay_end     = (state == S_PAY) && (sym_idx == PAY_END);
    // A stop arriving in the very cycle of the final accept still counts.
    assign run_done    = stop_q || stop ||
                         ((nf_q != '0) && ((run_frames + 1'b1) == nf_q));
    assign gap_end     = (state == S_GAP) && (pace == CNT_W'(1));

    // Reseed on every frame start; the payload reads the LFSR untouched since.
    assign lfsr_load = ((state == S_IDLE) && start) ||
                       (accept && pay_end && !run_done && (GAP_LEN == 0)) ||
                       gap_end;
    assign lfsr_adv  = accept && (state == S_PAY);

    pn_lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .adv     (lfsr_adv),
        .msb     (lfsr_msb),
        .nxt_msb (lfsr_nxt_msb)
    );

    // The symbol registers always hold the next symbol to offer; sym_valid
    // alone is gated by the pace counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sym_valid  <= 1'b0;
            sym_bit    <= 1'b0;
            sym_first  <= 1'b0;
            sym_last   <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
            sym_idx    <= '0;
            pace       <= '0;
            nf_q       <= '0;
            run_frames <= '0;
            stop_q     <= 1'b0;
        end else begin
            if ((state != S_IDLE) && stop) stop_q <= 1'b1;

            if (state == S_IDLE) begin
                if (start) begin
                    state      <= FIRST_ST;
                    busy       <= 1'b1;
                    sym_valid  <= 1'b1;
                    sym_bit    <= FIRST_BIT;
                    sym_first  <= 1'b1;
                    sym_last   <= 1'b0;
                    sym_idx    <= '0;
                    pace       <= '0;
                    nf_q       <= n_frames;
                    run_frames <= '0;
                    stop_q     <= 1'b0;
                end
            end else if (accept) begin
                sym_first <= 1'b0;
                sym_last  <= 1'b0;
                sym_valid <= (PACE_SYM == '0);
                pace      <= PACE_SYM;
                case (state)
                    S_PRE: begin
                        if (sym_idx == PRE_END) begin
                            state   <= S_SYNC;
                            sym_idx <= '0;
                            sym_bit <= SYNC_WORD[7];
                        end else begin
                            sym_idx <= sym_idx_inc;
                            sym_bit <= ~sym_idx_inc[0];
                        end
                    end
                    S_SYNC: begin
                        if (sym_idx == CNT_W'(7)) begin
                            state    <= S_PAY;
                            sym_idx  <= '0;
                            sym_bit  <= lfsr_msb;
                            sym_last <= (PAY_END == '0);
                        end else begin
                            sym_idx <= sym_idx_inc;
                            sym_bit <= SYNC_WORD[3'd7 - sym_idx_inc[2:0]];
                        end
                    end
                    S_PAY: begin
                        if (pay_end) begin
                            frame_cnt  <= frame_cnt + 1'b1;
                            run_frames <= run_frames + 1'b1;
                            if (run_done) begin
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                                sym_valid <= 1'b0;
                                pace      <= '0;
                            end else begin
                                sym_idx   <= '0;
                                sym_bit   <= FIRST_BIT;
                                sym_first <= 1'b1;
                                if (GAP_LEN == 0) begin
                                    state <= FIRST_ST;
                                end else begin
                                    // Gap and the last symbol's own pacing
                                    // interval run as one countdown.
                                    state     <= S_GAP;
                                    sym_valid <= 1'b0;
                                    pace      <= PACE_GAP;
                                end
                            end
                        end else begin
                            sym_idx  <= sym_idx_inc;
                            sym_bit  <= lfsr_nxt_msb;
                            sym_last <= (sym_idx_inc == PAY_END);
                        end
                    end
                    default: ;
                endcase
            end else if (pace != '0) begin
                pace <= pace - 1'b1;
                if (pace == CNT_W'(1)) begin
                    sym_valid <= 1'b1;
                    if (state == S_GAP) state <= FIRST_ST;
                end
            end
        end
    end

endmodule
